// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared definitions for the player-input front end: movement
//               codes (same encoding as the block logic), button indices in
//               grant-priority order, and the auto-repeat FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  // Movement codes presented to the block logic.
  typedef enum logic [2:0] {
    MOVE_CW    = 3'b000,
    MOVE_ACW   = 3'b001,
    MOVE_DOWN  = 3'b010,
    MOVE_LEFT  = 3'b011,
    MOVE_RIGHT = 3'b100,
    MOVE_NONE  = 3'b101
  } move_e;

  // Button indices; lower index wins arbitration.
  localparam int NUM_BTN   = 5;
  localparam int BTN_CW    = 0;
  localparam int BTN_ACW   = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  // Auto-repeat FSM states.
  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_WAIT = 2'd1,
    RPT_RUN  = 2'd2
  } rpt_state_e;

  // Map a button index onto its movement code.
  function automatic move_e btn_to_move(input int idx);
    case (idx)
      BTN_CW:    return MOVE_CW;
      BTN_ACW:   return MOVE_ACW;
      BTN_DOWN:  return MOVE_DOWN;
      BTN_LEFT:  return MOVE_LEFT;
      BTN_RIGHT: return MOVE_RIGHT;
      default:   return MOVE_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, debounce counter and rising-edge pulse
//               for one raw push-button.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               i_raw       - raw asynchronous button level
//               o_stable    - debounced level
//               o_press     - one-cycle pulse, coincident with the first
//                             cycle o_stable reads high
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press
);

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_stable) begin
        // Any return to the stable level restarts the qualification window.
        r_cnt <= '0;
      end else if (r_cnt == c_DEB_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
        // Pulse is raised on the same edge the level flips high, so the
        // press and the new stable level appear together.
        r_press  <= r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule
`default_nettype wire

// File: rtl/move_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : move_input_ctrl
// Description : Player-button front end. Debounces five buttons, auto-repeats
//               down/left/right while held, queues simultaneous requests and
//               issues one registered movement code per accepted event.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               enable       - low discards pending events, ignores new ones
//               clockwise, anti_clkwise, down, left, right - raw buttons
//               movement     - registered movement code, MOVE_NONE when idle
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clockwise,
  input  logic       anti_clkwise,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [2:0] movement
);

  localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_rpt_evt;
  logic [NUM_BTN-1:0] w_set;
  logic [NUM_BTN-1:0] w_grant;
  logic               w_found;
  logic [2:0]         w_move;

  logic [NUM_BTN-1:0] r_pending;
  logic [2:0]         r_movement;

  // Bit order follows the grant priority.
  assign w_raw = {right, left, down, anti_clkwise, clockwise};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (w_raw[gi]),
        .o_stable (w_stable[gi]),
        .o_press  (w_press[gi])
      );

      if (gi >= BTN_DOWN) begin : g_rpt
        rpt_state_e       r_state;
        logic [CNT_W-1:0] r_hold;

        // The FSM runs independently of enable so a held button keeps its
        // repeat cadence across a pause.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_state <= RPT_IDLE;
            r_hold  <= '0;
          end else if (!w_stable[gi]) begin
            r_state <= RPT_IDLE;
            r_hold  <= '0;
          end else begin
            case (r_state)
              RPT_IDLE: begin
                r_hold <= '0;
                if (w_press[gi]) r_state <= RPT_WAIT;
              end
              RPT_WAIT: begin
                if (r_hold == c_DLY_LAST) begin
                  r_state <= RPT_RUN;
                  r_hold  <= '0;
                end else begin
                  r_hold <= r_hold + CNT_W'(1);
                end
              end
              RPT_RUN: begin
                if (r_hold == c_PER_LAST) r_hold <= '0;
                else                      r_hold <= r_hold + CNT_W'(1);
              end
              default: begin
                r_state <= RPT_IDLE;
                r_hold  <= '0;
              end
            endcase
          end
        end

        // Gated by the stable level so the release cycle cannot fire.
        assign w_rpt_evt[gi] = w_stable[gi] &&
                               (((r_state == RPT_WAIT) && (r_hold == c_DLY_LAST)) ||
                                ((r_state == RPT_RUN)  && (r_hold == c_PER_LAST)));
      end else begin : g_norpt
        assign w_rpt_evt[gi] = 1'b0;
      end
    end
  endgenerate

  // Rotation buttons never repeat, so their stable levels have no consumer.
  logic w_unused_stable;
  assign w_unused_stable = &{1'b0, w_stable[BTN_ACW:BTN_CW]};

  assign w_set = w_press | w_rpt_evt;

  // Fixed-priority grant: lowest pending index wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_move  = MOVE_NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (r_pending[i] && !w_found) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
        w_move     = btn_to_move(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_pending  <= '0;
      r_movement <= MOVE_NONE;
    end else begin
      // A new event on a bit being granted re-arms it (set wins over clear).
      r_pending  <= w_set | (r_pending & ~w_grant);
      r_movement <= w_move;
    end
  end

  assign movement = r_movement;

endmodule
`default_nettype wire

// File: tb/tb_move_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_input_ctrl
// Description : Directed self-checking bench for move_input_ctrl with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, CNT_W=5.
//               Inputs change on the falling edge; sample k is taken on the
//               falling edge where cycle k's inputs are applied, so a button
//               raised at sample 0 yields its movement code at sample 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_input_ctrl;

  localparam logic [2:0] c_CW    = 3'b000;
  localparam logic [2:0] c_ACW   = 3'b001;
  localparam logic [2:0] c_DOWN  = 3'b010;
  localparam logic [2:0] c_LEFT  = 3'b011;
  localparam logic [2:0] c_RIGHT = 3'b100;
  localparam logic [2:0] c_NONE  = 3'b101;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clockwise;
  logic       anti_clkwise;
  logic       down;
  logic       left;
  logic       right;
  logic [2:0] movement;

  int n_vec;
  int n_err;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3),
    .CNT_W           (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clockwise    (clockwise),
    .anti_clkwise (anti_clkwise),
    .down         (down),
    .left         (left),
    .right        (right),
    .movement     (movement)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (movement !== c_NONE) begin
      n_err++;
      $display("FAIL reset_state movement=%b expected=%b", movement, c_NONE);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (movement !== c_NONE) begin
      n_err++;
      $display("FAIL post_reset_idle movement=%b expected=%b", movement, c_NONE);
    end
  endtask

  // Clean 6-cycle press of left: one 011 at sample 8, no repeat.
  task automatic test_single_left();
    logic [2:0] exp;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp = (k == 8) ? c_LEFT : c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL single_left k=%0d movement=%b expected=%b", k, movement, exp);
      end
      left = (k < 6);
    end
  endtask

  // Right bounces (2 high / 2 low) for 12 cycles, then 8 steady cycles.
  task automatic test_bounce_right();
    logic [2:0] exp;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp = (k == 20) ? c_RIGHT : c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL bounce_right k=%0d movement=%b expected=%b", k, movement, exp);
      end
      if (k < 12)      right = (((k / 2) % 2) == 0);
      else if (k < 20) right = 1'b1;
      else             right = 1'b0;
    end
  endtask

  // Down held 40 cycles: first at 8, repeat at 16, then every 3 up to 46.
  task automatic test_repeat_down();
    logic [2:0] exp;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      exp = ((k == 8) || ((k >= 16) && (k <= 46) && (((k - 16) % 3) == 0))) ? c_DOWN : c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL repeat_down k=%0d movement=%b expected=%b", k, movement, exp);
      end
      down = (k < 40);
    end
  endtask

  // Clockwise and left together: cw wins at 8, left follows at 9.
  task automatic test_priority();
    logic [2:0] exp;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp = (k == 8) ? c_CW : ((k == 9) ? c_LEFT : c_NONE);
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL priority k=%0d movement=%b expected=%b", k, movement, exp);
      end
      clockwise = (k < 6);
      left      = (k < 6);
    end
  endtask

  // Clockwise held long (no repeat); anti-clockwise tapped mid-hold.
  task automatic test_rotate_hold();
    logic [2:0] exp;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      exp = (k == 8) ? c_CW : ((k == 18) ? c_ACW : c_NONE);
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL rotate_hold k=%0d movement=%b expected=%b", k, movement, exp);
      end
      clockwise    = (k < 40);
      anti_clkwise = (k >= 10) && (k < 16);
    end
  endtask

  // Reset on the edge where the first repeat would be shown; fresh press later.
  task automatic test_reset_mid_hold();
    logic [2:0] exp;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      exp = ((k == 8) || (k == 24) || (k == 32) || (k == 35)) ? c_DOWN : c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL reset_mid_hold k=%0d movement=%b expected=%b", k, movement, exp);
      end
      down  = (k < 30);
      reset = (k == 15);
    end
  endtask

  // Enable dropped while left is pending; then a hold spanning a pause.
  task automatic test_enable();
    logic [2:0] exp;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      exp = c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL enable_drop k=%0d movement=%b expected=%b", k, movement, exp);
      end
      left   = (k < 6);
      enable = (k != 7);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp = ((k == 16) || (k == 19) || (k == 22) || (k == 25)) ? c_LEFT : c_NONE;
      n_vec++;
      if (movement !== exp) begin
        n_err++;
        $display("FAIL enable_resume k=%0d movement=%b expected=%b", k, movement, exp);
      end
      left   = (k < 20);
      enable = (k >= 11);
    end
    enable = 1'b1;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    clockwise    = 1'b0;
    anti_clkwise = 1'b0;
    down         = 1'b0;
    left         = 1'b0;
    right        = 1'b0;

    test_reset();
    test_single_left();
    test_bounce_right();
    test_repeat_down();
    test_priority();
    test_rotate_hold();
    test_reset_mid_hold();
    test_enable();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
